// File: rtl/eth_rx.sv
// Receive-side Ethernet/802.1Q/IPv4/UDP filter: strips the fixed headers, streams
// the UDP payload to the application and reports a per-frame FCS verdict.
module eth_rx #(
    parameter int          DATA_W      = 16,
    parameter int          KEEP_W      = DATA_W / 8,
    parameter int          LEN_W       = $clog2(KEEP_W + 1),
    parameter int          PKT_LEN_W   = 16,
    parameter int          VLAN_TAG    = 1,
    parameter logic [47:0] MAC_ADDR    = 48'h000000FCD4F2,
    parameter logic [31:0] IP_DST_ADDR = {8'd206, 8'd200, 8'd127, 8'd128},
    parameter logic [7:0]  PROTOCOL    = 8'd17,
    parameter logic [15:0] DST_PORT    = 16'd18170,
    parameter logic [31:0] CRC_RESIDUE = 32'hC704DD7B,
    parameter int          HEAD_N      = (VLAN_TAG != 0) ? 54 : 50
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              mac_valid_i,
    input  logic              mac_ctrl_v_i,
    input  logic [DATA_W-1:0] mac_data_i,
    input  logic              mac_start_i,
    input  logic              mac_idle_i,
    input  logic              mac_term_i,
    input  logic [LEN_W-1:0]  mac_term_len_i,
    output logic              app_valid_o,
    output logic [DATA_W-1:0] app_data_o,
    output logic [LEN_W-1:0]  app_len_o,
    output logic              app_last_o,
    output logic              app_done_o,
    output logic              app_ok_o,
    output logic              app_cancel_o
);

    localparam int HC_W      = $clog2(HEAD_N + 1);
    localparam int TAG_B     = (VLAN_TAG != 0) ? 4 : 0;
    localparam int ETYPE_OFF = 20 + TAG_B;
    localparam int IP_OFF    = ETYPE_OFF + 2;
    localparam int UDP_OFF   = IP_OFF + 20;

    if (!((DATA_W == 8 || DATA_W == 16) && (HEAD_N % KEEP_W == 0))) begin : g_bad_width
        $error("eth_rx: DATA_W must be 8 or 16 and HEAD_N a multiple of KEEP_W");
    end

    typedef enum logic [2:0] {IDLE, HEAD, DATA, FOOT, DROP} state_t;

    state_t                 state_reg;
    logic [HC_W-1:0]        head_cnt_reg;
    logic [47:0]            dst_mac_reg, dst_mac_next;
    logic [15:0]            tpid_reg, tpid_next;
    logic [15:0]            etype_reg, etype_next;
    logic [7:0]             proto_reg, proto_next;
    logic [31:0]            ip_dst_reg, ip_dst_next;
    logic [15:0]            dst_port_reg, dst_port_next;
    logic [15:0]            udp_len_reg, udp_len_next;
    logic [PKT_LEN_W-1:0]   payload_rem_reg;
    logic                   payload_seen_reg;
    logic [2:0]             post_cnt_reg, post_cnt_next;
    logic [31:0]            crc_reg, crc_next, crc_out;

    logic [7:0]             lane_byte [KEEP_W];
    logic [HC_W-1:0]        lane_off  [KEEP_W];
    logic [KEEP_W-1:0]      crc_en;

    logic                   head_last, hdr_ok, rem_last, abort, fcs_good;
    logic [LEN_W-1:0]       beat_len, post_add;
    logic [3:0]             post_sum;

    function automatic logic in_rng(input logic [HC_W-1:0] off, input int lo, input int n);
        return (int'(off) >= lo) && (int'(off) < lo + n);
    endfunction

    // Reflected CRC-32 (poly 0x04C11DB7), one byte, LSB first as on the wire
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_lane
        assign lane_byte[gi] = mac_data_i[8*gi +: 8];
        assign lane_off[gi]  = head_cnt_reg + HC_W'(gi);
        assign crc_en[gi]    = ((state_reg == HEAD) && (int'(lane_off[gi]) >= 8)) ||
                               (((state_reg == DATA) || (state_reg == FOOT)) &&
                                (!mac_term_i || (LEN_W'(gi) < mac_term_len_i)));
    end

    // Header fields are big-endian, so each captured byte shifts in at the bottom
    always_comb begin
        dst_mac_next  = dst_mac_reg;
        tpid_next     = tpid_reg;
        etype_next    = etype_reg;
        proto_next    = proto_reg;
        ip_dst_next   = ip_dst_reg;
        dst_port_next = dst_port_reg;
        udp_len_next  = udp_len_reg;
        crc_next      = crc_reg;
        for (int i = 0; i < KEEP_W; i++) begin
            if (state_reg == HEAD) begin
                if (in_rng(lane_off[i], 8, 6))            dst_mac_next  = {dst_mac_next[39:0], lane_byte[i]};
                if (in_rng(lane_off[i], 20, 2))           tpid_next     = {tpid_next[7:0], lane_byte[i]};
                if (in_rng(lane_off[i], ETYPE_OFF, 2))    etype_next    = {etype_next[7:0], lane_byte[i]};
                if (in_rng(lane_off[i], IP_OFF + 9, 1))   proto_next    = lane_byte[i];
                if (in_rng(lane_off[i], IP_OFF + 16, 4))  ip_dst_next   = {ip_dst_next[23:0], lane_byte[i]};
                if (in_rng(lane_off[i], UDP_OFF + 2, 2))  dst_port_next = {dst_port_next[7:0], lane_byte[i]};
                if (in_rng(lane_off[i], UDP_OFF + 4, 2))  udp_len_next  = {udp_len_next[7:0], lane_byte[i]};
            end
            if (crc_en[i]) crc_next = crc_byte(crc_next, lane_byte[i]);
        end
        for (int k = 0; k < 32; k++) begin
            crc_out[k] = crc_next[31-k];
        end
    end

    always_comb begin
        head_last = (head_cnt_reg == HC_W'(HEAD_N - KEEP_W));
        hdr_ok    = (dst_mac_next == MAC_ADDR) &&
                    ((VLAN_TAG == 0) || (tpid_next == 16'h8100)) &&
                    (etype_next == 16'h0800) && (proto_next == PROTOCOL) &&
                    (ip_dst_next == IP_DST_ADDR) && (dst_port_next == DST_PORT) &&
                    (udp_len_next > 16'd8);
        rem_last  = (payload_rem_reg <= PKT_LEN_W'(KEEP_W));
        beat_len  = rem_last ? LEN_W'(payload_rem_reg) : LEN_W'(KEEP_W);
        abort     = mac_idle_i || (mac_ctrl_v_i && !mac_term_i) ||
                    (mac_term_i && ((state_reg == HEAD) || (state_reg == DATA)));
        fcs_good  = (crc_out == CRC_RESIDUE);
        // Bytes beyond the payload: tail of the last payload beat, pad, FCS
        if (state_reg == DATA)  post_add = LEN_W'(KEEP_W) - beat_len;
        else if (mac_term_i)    post_add = mac_term_len_i;
        else                    post_add = LEN_W'(KEEP_W);
        post_sum      = {1'b0, post_cnt_reg} + 4'(post_add);
        post_cnt_next = (post_sum >= 4'd4) ? 3'd4 : post_sum[2:0];
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_reg        <= IDLE;
            head_cnt_reg     <= '0;
            dst_mac_reg      <= '0;
            tpid_reg         <= '0;
            etype_reg        <= '0;
            proto_reg        <= '0;
            ip_dst_reg       <= '0;
            dst_port_reg     <= '0;
            udp_len_reg      <= '0;
            payload_rem_reg  <= '0;
            payload_seen_reg <= 1'b0;
            post_cnt_reg     <= '0;
            crc_reg          <= '1;
            app_valid_o      <= 1'b0;
            app_data_o       <= '0;
            app_len_o        <= '0;
            app_last_o       <= 1'b0;
            app_done_o       <= 1'b0;
            app_ok_o         <= 1'b0;
            app_cancel_o     <= 1'b0;
        end else begin
            app_valid_o  <= 1'b0;
            app_last_o   <= 1'b0;
            app_done_o   <= 1'b0;
            app_ok_o     <= 1'b0;
            app_cancel_o <= 1'b0;
            if (mac_valid_i) begin
                crc_reg      <= crc_next;
                dst_mac_reg  <= dst_mac_next;
                tpid_reg     <= tpid_next;
                etype_reg    <= etype_next;
                proto_reg    <= proto_next;
                ip_dst_reg   <= ip_dst_next;
                dst_port_reg <= dst_port_next;
                udp_len_reg  <= udp_len_next;
                if (mac_start_i) begin
                    // A start in any state opens a new frame in HEAD
                    app_cancel_o     <= payload_seen_reg &&
                                        ((state_reg == DATA) || (state_reg == FOOT));
                    state_reg        <= HEAD;
                    head_cnt_reg     <= HC_W'(KEEP_W);
                    crc_reg          <= '1;
                    payload_seen_reg <= 1'b0;
                    post_cnt_reg     <= '0;
                end else begin
                    case (state_reg)
                        DROP: begin
                            if (mac_term_i) state_reg <= IDLE;
                        end
                        HEAD, DATA, FOOT: begin
                            if (abort) begin
                                app_cancel_o <= payload_seen_reg && (state_reg != HEAD);
                                state_reg    <= IDLE;
                            end else if (state_reg == HEAD) begin
                                head_cnt_reg <= head_cnt_reg + HC_W'(KEEP_W);
                                if (head_last) begin
                                    state_reg       <= hdr_ok ? DATA : DROP;
                                    payload_rem_reg <= PKT_LEN_W'(udp_len_next - 16'd8);
                                end
                            end else if (state_reg == DATA) begin
                                app_valid_o      <= 1'b1;
                                app_data_o       <= mac_data_i;
                                app_len_o        <= beat_len;
                                payload_seen_reg <= 1'b1;
                                payload_rem_reg  <= payload_rem_reg - PKT_LEN_W'(beat_len);
                                if (rem_last) begin
                                    app_last_o   <= 1'b1;
                                    state_reg    <= FOOT;
                                    post_cnt_reg <= post_cnt_next;
                                end
                            end else begin
                                post_cnt_reg <= post_cnt_next;
                                if (mac_term_i) begin
                                    app_done_o <= 1'b1;
                                    app_ok_o   <= fcs_good && (post_cnt_next >= 3'd4);
                                    state_reg  <= IDLE;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_rx.sv
// Directed plus randomized frames against a byte-level frame model of eth_rx.
module tb_eth_rx;
    localparam int          DATA_W  = 16;
    localparam int          LEN_W   = 2;
    localparam logic [15:0] PORT_OK = 16'd18170;

    logic              clk = 1'b0;
    logic              nreset = 1'b0;
    logic              mac_valid_i = 1'b0;
    logic              mac_ctrl_v_i = 1'b0;
    logic [DATA_W-1:0] mac_data_i = '0;
    logic              mac_start_i = 1'b0;
    logic              mac_idle_i = 1'b0;
    logic              mac_term_i = 1'b0;
    logic [LEN_W-1:0]  mac_term_len_i = '0;
    logic              app_valid_o;
    logic [DATA_W-1:0] app_data_o;
    logic [LEN_W-1:0]  app_len_o;
    logic              app_last_o;
    logic              app_done_o;
    logic              app_ok_o;
    logic              app_cancel_o;

    eth_rx dut (
        .clk(clk), .nreset(nreset),
        .mac_valid_i(mac_valid_i), .mac_ctrl_v_i(mac_ctrl_v_i), .mac_data_i(mac_data_i),
        .mac_start_i(mac_start_i), .mac_idle_i(mac_idle_i), .mac_term_i(mac_term_i),
        .mac_term_len_i(mac_term_len_i),
        .app_valid_o(app_valid_o), .app_data_o(app_data_o), .app_len_o(app_len_o),
        .app_last_o(app_last_o), .app_done_o(app_done_o), .app_ok_o(app_ok_o),
        .app_cancel_o(app_cancel_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  len;
        logic        last;
    } beat_t;

    beat_t      obs_beats[$];
    logic       obs_ok[$];
    int         obs_done_cyc[$];
    int         cancel_n = 0;
    logic [7:0] frame[$];
    logic [7:0] payload[$];
    int         checks = 0;
    int         errors = 0;

    always @(negedge clk) begin
        if (app_valid_o) obs_beats.push_back('{app_data_o, app_len_o, app_last_o});
        if (app_done_o) begin
            obs_ok.push_back(app_ok_o);
            obs_done_cyc.push_back(cyc);
        end
        if (app_cancel_o) cancel_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_add(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic push_n(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) frame.push_back(v[8*i +: 8]);
    endtask

    // Wire image: preamble, MAC+VLAN, IPv4, UDP, payload, pad to 60, FCS (fcs_keep bytes)
    task automatic build(input logic [15:0] port, input int plen, input int ulen,
                         input bit bad_fcs, input int fcs_keep);
        logic [31:0] crc, fcs;
        logic [7:0]  b;
        frame.delete();
        payload.delete();
        repeat (7) frame.push_back(8'h55);
        frame.push_back(8'hD5);
        push_n(32'h0000_0000, 2);
        push_n(32'h00FC_D4F2, 4);
        push_n($urandom, 4);
        push_n($urandom, 2);
        push_n(32'h8100, 2);
        push_n($urandom, 2);
        push_n(32'h0800, 2);
        push_n(32'h4500, 2);
        push_n(32'(20 + ulen), 2);
        push_n($urandom, 4);
        frame.push_back(8'h40);
        frame.push_back(8'd17);
        push_n($urandom, 2);
        push_n($urandom, 4);
        push_n({8'd206, 8'd200, 8'd127, 8'd128}, 4);
        push_n($urandom, 2);
        push_n({16'd0, port}, 2);
        push_n(32'(ulen), 2);
        push_n($urandom, 2);
        for (int i = 0; i < plen; i++) begin
            b = 8'($urandom);
            payload.push_back(b);
            frame.push_back(b);
        end
        while (frame.size() - 8 < 60) frame.push_back(8'h00);
        crc = 32'hFFFF_FFFF;
        for (int i = 8; i < frame.size(); i++) crc = crc_add(crc, frame[i]);
        fcs = ~crc;
        if (bad_fcs) fcs[13] = ~fcs[13];
        for (int i = 0; i < fcs_keep; i++) frame.push_back(fcs[8*i +: 8]);
    endtask

    task automatic drive(input logic v, input logic st, input logic idl, input logic trm,
                         input logic ctrl, input logic [15:0] d, input logic [1:0] tl);
        @(negedge clk);
        mac_valid_i    = v;
        mac_start_i    = st;
        mac_idle_i     = idl;
        mac_term_i     = trm;
        mac_ctrl_v_i   = ctrl;
        mac_data_i     = d;
        mac_term_len_i = tl;
    endtask

    task automatic idle_beats(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0707, 2'd0);
    endtask

    task automatic send(input int stall_at, input int stall_n, input int cut_at,
                        input bit cut_rst, input bit term0, output int term_cyc);
        int nb, n;
        logic [15:0] d;
        term_cyc = -1;
        nb = (frame.size() + 1) / 2;
        for (int b = 0; b < nb; b++) begin
            if (b == cut_at) begin
                if (cut_rst) begin
                    @(negedge clk);
                    nreset = 1'b0;
                    mac_valid_i = 1'b0;
                    @(negedge clk);
                    chk("rst.valid", 32'(app_valid_o), 0);
                    chk("rst.last", 32'(app_last_o), 0);
                    chk("rst.done", 32'(app_done_o), 0);
                    chk("rst.cancel", 32'(app_cancel_o), 0);
                    nreset = 1'b1;
                end else begin
                    idle_beats(1);
                end
                return;
            end
            if (b == stall_at)
                repeat (stall_n) drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                                       1'($urandom), 16'($urandom), 2'($urandom));
            n = frame.size() - 2 * b;
            if (n > 2) n = 2;
            d = {(n == 2) ? frame[2*b+1] : 8'h00, frame[2*b]};
            if (b == nb - 1 && !(term0 && n == 2)) begin
                drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, d, 2'(n));
                term_cyc = cyc;
            end else begin
                drive(1'b1, b == 0, 1'b0, 1'b0, b == 0, d, 2'd0);
            end
        end
        if (term0 && (frame.size() % 2 == 0)) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h07FD, 2'd0);
            term_cyc = cyc;
        end
    endtask

    // Expected payload beats come straight from the payload bytes chunked into 2-byte beats
    task automatic check_frame(input string name, input int exp_nb, input bit exp_done,
                               input bit exp_ok, input int exp_cancel, input int term_cyc);
        int plen, len;
        logic [15:0] d, mask;
        idle_beats(3);
        plen = payload.size();
        chk({name, ".beats"}, obs_beats.size(), exp_nb);
        for (int i = 0; i < exp_nb && i < obs_beats.size(); i++) begin
            len  = (plen - 2 * i >= 2) ? 2 : plen - 2 * i;
            d    = {(len == 2) ? payload[2*i+1] : 8'h00, payload[2*i]};
            mask = (len == 2) ? 16'hFFFF : 16'h00FF;
            chk({name, ".data"}, obs_beats[i].data & mask, d);
            chk({name, ".len"}, obs_beats[i].len, len);
            chk({name, ".last"}, obs_beats[i].last, (2 * i + 2 >= plen));
        end
        chk({name, ".done"}, obs_ok.size(), exp_done);
        if (exp_done && obs_ok.size() > 0) begin
            chk({name, ".ok"}, obs_ok[0], exp_ok);
            chk({name, ".lat"}, obs_done_cyc[0] - term_cyc, 1);
        end
        chk({name, ".cancel"}, cancel_n, exp_cancel);
        $display("frame %-10s plen=%0d beats=%0d done=%0d ok=%0d cancel=%0d", name, plen,
                 obs_beats.size(), obs_ok.size(), (obs_ok.size() > 0) ? obs_ok[0] : 1'b0, cancel_n);
        @(posedge clk);
        #1;
        obs_beats.delete();
        obs_ok.delete();
        obs_done_cyc.delete();
        cancel_n = 0;
    endtask

    initial begin
        int tc, plen;
        bit good, bad, t0;
        repeat (3) @(negedge clk);
        chk("reset.valid", 32'(app_valid_o), 0);
        chk("reset.data", 32'(app_data_o), 0);
        chk("reset.len", 32'(app_len_o), 0);
        chk("reset.last", 32'(app_last_o), 0);
        chk("reset.done", 32'(app_done_o), 0);
        chk("reset.ok", 32'(app_ok_o), 0);
        chk("reset.cancel", 32'(app_cancel_o), 0);
        nreset = 1'b1;
        idle_beats(2);

        build(PORT_OK, 4, 12, 0, 4);      send(-1, 0, -1, 0, 0, tc); check_frame("good4", 2, 1, 1, 0, tc);
        build(PORT_OK, 4, 12, 1, 4);      send(-1, 0, -1, 0, 0, tc); check_frame("badfcs", 2, 1, 0, 0, tc);
        build(16'd1234, 4, 12, 0, 4);     send(-1, 0, -1, 0, 0, tc); check_frame("badport", 0, 0, 0, 0, tc);
        build(PORT_OK, 5, 13, 0, 4);      send(-1, 0, -1, 0, 0, tc); check_frame("odd5", 3, 1, 1, 0, tc);
        build(PORT_OK, 6, 14, 0, 4);      send(-1, 0, 28, 0, 0, tc); check_frame("idlecut", 1, 0, 0, 1, tc);
        build(PORT_OK, 7, 15, 0, 4);      send(-1, 0, -1, 0, 0, tc); check_frame("aftercut", 4, 1, 1, 0, tc);
        build(PORT_OK, 10, 18, 0, 4);     send(10, 3, -1, 0, 0, tc); check_frame("stall", 5, 1, 1, 0, tc);
        build(PORT_OK, 10, 18, 0, 4);     send(-1, 0, 29, 1, 0, tc); check_frame("rstcut", 2, 0, 0, 0, tc);
        build(PORT_OK, 3, 11, 0, 4);      send(-1, 0, -1, 0, 1, tc); check_frame("term0", 2, 1, 1, 0, tc);
        build(PORT_OK, 0, 8, 0, 4);       send(-1, 0, -1, 0, 0, tc); check_frame("ulen8", 0, 0, 0, 0, tc);
        build(PORT_OK, 20, 28, 0, 2);     send(-1, 0, -1, 0, 0, tc); check_frame("shortfcs", 10, 1, 0, 0, tc);

        for (int f = 0; f < 8; f++) begin
            plen = $urandom_range(1, 40);
            good = 1'($urandom_range(0, 1));
            bad  = ($urandom_range(0, 3) == 0);
            t0   = 1'($urandom_range(0, 1));
            build(good ? PORT_OK : 16'($urandom_range(0, 18000)), plen, plen + 8, bad, 4);
            send(-1, 0, -1, 0, t0, tc);
            check_frame("random", good ? (plen + 1) / 2 : 0, good, !bad, 0, tc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
